// File: rtl/divide_unit_pkg.sv
// Shared divider constants: RISC-V M-extension divide op encodings and FSM states.
package divide_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/divide_unit_step.sv
// One restoring-division step: trial subtract of the divisor, restore on borrow.
module divide_step #(
  parameter int unsigned N = 32
) (
  input  logic [N:0]   part,
  input  logic [N-1:0] dvs,
  output logic [N-1:0] rem_next,
  output logic         qbit
);

  logic [N:0] trial;

  // part < 2*dvs, so the signed (N+1)-bit difference cannot overflow
  assign trial    = part - {1'b0, dvs};
  assign qbit     = ~trial[N];
  assign rem_next = qbit ? trial[N-1:0] : part[N-1:0];

endmodule

// File: rtl/divide_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, fixed N+1 cycle latency.
module divide_unit
  import divide_unit_pkg::*;
#(
  parameter int unsigned N = DIV_WIDTH
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [1:0]   OP,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] RESULT
);

  localparam int unsigned CW = $clog2(N + 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  div_op_e       op_q;
  logic          quo_neg_q, rem_neg_q, bzero_q;
  logic [N-1:0]  rem_q, quo_q, dvs_q;

  div_op_e       op_c;
  logic          accept_c, sgn_c, a_neg_c, b_neg_c;
  logic [N-1:0]  a_mag_c, b_mag_c;
  logic [N:0]    part_c;
  logic [N-1:0]  step_rem_c, quo_fix_c, rem_fix_c, result_c;
  logic          step_qbit_c;

  // Operand capture: magnitudes and sign flags of the request
  assign op_c     = div_op_e'(OP);
  assign sgn_c    = op_is_signed(op_c);
  assign a_neg_c  = sgn_c & A[N-1];
  assign b_neg_c  = sgn_c & B[N-1];
  assign a_mag_c  = a_neg_c ? (N'(0) - A) : A;
  assign b_mag_c  = b_neg_c ? (N'(0) - B) : B;
  // BUSY still covers the DONE cycle, which is already spent in IDLE
  assign accept_c = (state_q == ST_IDLE) && !BUSY && START;

  assign part_c = {rem_q, quo_q[N-1]};

  divide_step #(.N(N)) u_step (
    .part     (part_c),
    .dvs      (dvs_q),
    .rem_next (step_rem_c),
    .qbit     (step_qbit_c)
  );

  // Sign fix-up; divide-by-zero quotient forced to all-ones for every op
  assign quo_fix_c = bzero_q   ? {N{1'b1}} :
                     quo_neg_q ? (N'(0) - quo_q) : quo_q;
  assign rem_fix_c = rem_neg_q ? (N'(0) - rem_q) : rem_q;
  assign result_c  = op_is_rem(op_q) ? rem_fix_c : quo_fix_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept_c) state_d = ST_CALC;
      ST_CALC:   if (cnt_q == CW'(1)) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_DIV;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RESULT    <= '0;
    end else begin
      state_q <= state_d;
      DONE    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            BUSY      <= 1'b1;
            op_q      <= op_c;
            quo_neg_q <= a_neg_c ^ b_neg_c;
            rem_neg_q <= a_neg_c;
            bzero_q   <= (B == '0);
            rem_q     <= '0;
            quo_q     <= a_mag_c;
            dvs_q     <= b_mag_c;
            cnt_q     <= CW'(N);
          end else if (DONE) begin
            BUSY <= 1'b0;
          end
        end
        ST_CALC: begin
          rem_q <= step_rem_c;
          quo_q <= {quo_q[N-2:0], step_qbit_c};
          cnt_q <= cnt_q - CW'(1);
        end
        ST_FINISH: begin
          DONE   <= 1'b1;
          RESULT <= result_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// Scoreboard bench for divide_unit: directed corner cases plus randomized ops.
module tb_divide_unit;

  localparam int unsigned N   = 32;
  localparam int unsigned LAT = N + 1;

  logic         CLK = 1'b0;
  logic         RST, START;
  logic [N-1:0] A, B;
  logic [1:0]   OP;
  logic         BUSY, DONE;
  logic [N-1:0] RESULT;

  divide_unit #(.N(N)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .A      (A),
    .B      (B),
    .OP     (OP),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] res;
    int unsigned  due;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic plus the architectural special cases
  function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [1:0] op);
    logic         is_rem;
    logic         sgn;
    logic [N-1:0] min_neg;
    is_rem  = op[1];
    sgn     = ~op[0];
    min_neg = {1'b1, {(N-1){1'b0}}};
    if (b == '0) return is_rem ? a : {N{1'b1}};
    if (sgn) begin
      if (a == min_neg && b == {N{1'b1}}) return is_rem ? '0 : a;
      return is_rem ? N'($signed(a) % $signed(b)) : N'($signed(a) / $signed(b));
    end
    return is_rem ? a % b : a / b;
  endfunction

  // Monitor: every DONE must match the oldest outstanding request
  always @(negedge CLK) begin
    if (DONE) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got DONE=1 result 0x%0h expected no DONE at cycle %0d",
                 RESULT, cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, " result"}, 64'(RESULT), 64'(mon_e.res));
        check({mon_e.name, " latency"}, 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic check_drained(input string name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s missing_done: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op,
                       input logic [N-1:0] exp, input string name);
    @(negedge CLK);
    A = a; B = b; OP = op; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    sb.push_back('{exp, cyc + LAT, name});
    // scramble inputs: the latched operation must not notice
    A  = $urandom;
    B  = $urandom;
    OP = 2'($urandom);
    repeat (LAT + 1) @(posedge CLK);
    #1;
    check({name, " busy_clear"}, 64'(BUSY), 64'(0));
    check_drained(name);
    check({name, " hold"}, 64'(RESULT), 64'(exp));
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic [1:0]   rop;
    RST = 1'b1; START = 1'b0; A = '0; B = '0; OP = 2'b00;
    repeat (3) @(posedge CLK);
    #1;
    check("reset busy", 64'(BUSY), 64'(0));
    check("reset done", 64'(DONE), 64'(0));
    check("reset result", 64'(RESULT), 64'(0));
    RST = 1'b0;

    issue(32'd100, 32'd7, 2'b01, 32'd14, "divu_100_7");
    issue(32'd100, 32'd7, 2'b11, 32'd2, "remu_100_7");
    issue(32'hFFFFFFF9, 32'd2, 2'b00, 32'hFFFFFFFD, "div_m7_2");
    issue(32'hFFFFFFF9, 32'd2, 2'b10, 32'hFFFFFFFF, "rem_m7_2");
    issue(32'd7, 32'hFFFFFFFE, 2'b00, 32'hFFFFFFFD, "div_7_m2");
    issue(32'd5, 32'd0, 2'b00, 32'hFFFFFFFF, "div_by0");
    issue(32'd5, 32'd0, 2'b01, 32'hFFFFFFFF, "divu_by0");
    issue(32'd5, 32'd0, 2'b10, 32'd5, "rem_by0");
    issue(32'd5, 32'd0, 2'b11, 32'd5, "remu_by0");
    issue(32'h80000000, 32'hFFFFFFFF, 2'b00, 32'h80000000, "div_ovf");
    issue(32'h80000000, 32'hFFFFFFFF, 2'b10, 32'd0, "rem_ovf");
    issue(32'h80000000, 32'hFFFFFFFF, 2'b01, 32'd0, "divu_ovf");
    issue(32'h80000000, 32'hFFFFFFFF, 2'b11, 32'h80000000, "remu_ovf");

    // START while busy (CALC and the FINISH/DONE edges) must be ignored
    @(negedge CLK);
    A = 32'd100; B = 32'd7; OP = 2'b01; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    sb.push_back('{32'd14, cyc + LAT, "busy_start"});
    repeat (4) @(posedge CLK);
    #1;
    A = 32'd9; B = 32'd4; OP = 2'b00; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (27) @(posedge CLK);
    #1;
    START = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    START = 1'b0;
    check("busy_start busy_clear", 64'(BUSY), 64'(0));
    check_drained("busy_start");
    check("busy_start hold", 64'(RESULT), 64'(14));
    repeat (40) @(posedge CLK);
    #1;
    check("busy_start no_restart", 64'(BUSY), 64'(0));

    // Reset in the middle of CALC aborts without DONE
    @(negedge CLK);
    A = 32'd1000; B = 32'd3; OP = 2'b01; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check("abort busy", 64'(BUSY), 64'(0));
    check("abort done", 64'(DONE), 64'(0));
    check("abort result", 64'(RESULT), 64'(0));
    RST = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    check("abort idle", 64'(BUSY), 64'(0));
    issue(32'd1000, 32'd3, 2'b11, 32'd1, "after_abort");

    for (int i = 0; i < 1200; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = {N{1'b1}};
        2:       rb = N'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      rop = 2'($urandom_range(0, 3));
      issue(ra, rb, rop, model(ra, rb, rop), "rand");
    end

    check_drained("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
